// File: rtl/exec_unit_pipe.sv
// exec_unit_pipe
//   Registered execute stage between decode/register-read and memory.
//   Picks forwarded or register/immediate operands, runs the ALU, and
//   registers result, first operand and status {written, C, N, Z}.
//   Operations are accepted through a valid/ready handshake. A synchronous
//   flush kills work that is still in flight.
//
//   Optional feature macro: EXEC_MUL_EN
//     defined   - opcode 4'b1011 is an iterative shift-add multiply
//                 (one multiplier bit per cycle, WIDTH cycles busy)
//     undefined - no multiplier; 4'b1011 decodes as ADD; in_ready is always 1
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid / in_ready     operation handshake
//   flush                   synchronous kill of accept / in-flight multiply
//   imm_or_reg              1: op2 base is reg_dst, 0: immediate
//   sel_src, sel_dst        forwarding select (01 EX, 10 MEM, else register)
//   alu_ctrl                operation code
//   reg_src, reg_dst, immediate, src/dst_from_ex, src/dst_from_mem  operands
//   out_valid               one-cycle pulse when new results are written
//   alu_result, alu_first_operand, status   registered results
module exec_unit_pipe #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  input  logic             imm_or_reg,
  input  logic [1:0]       sel_src,
  input  logic [1:0]       sel_dst,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] reg_src,
  input  logic [WIDTH-1:0] reg_dst,
  input  logic [WIDTH-1:0] immediate,
  input  logic [WIDTH-1:0] src_from_ex,
  input  logic [WIDTH-1:0] dst_from_ex,
  input  logic [WIDTH-1:0] src_from_mem,
  input  logic [WIDTH-1:0] dst_from_mem,
  output logic             out_valid,
  output logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] alu_first_operand,
  output logic [3:0]       status
);

  logic [WIDTH-1:0] w_op1, w_op2, w_op2_base, w_res;
  logic [WIDTH:0]   w_wide;
  logic             w_c, w_accept, w_mul_op, w_sc_done, w_mul_done;
  logic [3:0]       w_st;
  logic [WIDTH-1:0] w_mul_res, w_mul_op1;
  logic [3:0]       w_mul_st;

  // Operand forwarding
  always_comb begin
    w_op2_base = imm_or_reg ? reg_dst : immediate;
    case (sel_src)
      2'b01:   w_op1 = src_from_ex;
      2'b10:   w_op1 = src_from_mem;
      default: w_op1 = reg_src;
    endcase
    case (sel_dst)
      2'b01:   w_op2 = dst_from_ex;
      2'b10:   w_op2 = dst_from_mem;
      default: w_op2 = w_op2_base;
    endcase
  end

  // Single-cycle ALU. Shifts run one bit wider so the last bit shifted out
  // lands in the extra bit; amounts of 0 or beyond WIDTH leave it clear.
  always_comb begin
    w_wide = '0;
    w_res  = '0;
    w_c    = 1'b0;
    case (alu_ctrl)
      4'b0001: begin
        w_wide = {1'b0, w_op2} - {1'b0, w_op1};
        w_res  = w_wide[WIDTH-1:0];
        w_c    = w_wide[WIDTH];
      end
      4'b0010: w_res = w_op1 & w_op2;
      4'b0011: w_res = w_op1 | w_op2;
      4'b0100: begin
        w_wide = {1'b0, w_op1} << w_op2;
        w_res  = w_wide[WIDTH-1:0];
        w_c    = w_wide[WIDTH];
      end
      4'b0101: begin
        w_wide = {w_op1, 1'b0} >> w_op2;
        w_res  = w_wide[WIDTH:1];
        w_c    = w_wide[0];
      end
      4'b0110: w_res = ~w_op1;
      4'b0111: w_res = w_op2;
      4'b1000: begin
        w_wide = {1'b0, w_op1} + {{WIDTH{1'b0}}, 1'b1};
        w_res  = w_wide[WIDTH-1:0];
        w_c    = w_wide[WIDTH];
      end
      4'b1001: begin
        w_wide = {1'b0, w_op1} - {{WIDTH{1'b0}}, 1'b1};
        w_res  = w_wide[WIDTH-1:0];
        w_c    = w_wide[WIDTH];
      end
      4'b1010: w_res = w_op1;
      default: begin
        w_wide = {1'b0, w_op1} + {1'b0, w_op2};
        w_res  = w_wide[WIDTH-1:0];
        w_c    = w_wide[WIDTH];
      end
    endcase
    w_st = {1'b1, w_c, w_res[WIDTH-1], ~|w_res};
  end

  assign w_accept  = in_valid & in_ready & ~flush;
  assign w_sc_done = w_accept & ~w_mul_op;

`ifdef EXEC_MUL_EN
  typedef enum logic {IDLE, MUL_BUSY} state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_mcand, r_acc, w_acc_step;
  logic [WIDTH-1:0]   r_mplier, r_mop1;

  assign w_mul_op   = (alu_ctrl == 4'b1011);
  assign w_acc_step = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_res  = w_acc_step[WIDTH-1:0];
  assign w_mul_op1  = r_mop1;
  assign w_mul_st   = {1'b1, |w_acc_step[2*WIDTH-1:WIDTH],
                       w_acc_step[WIDTH-1], ~|w_acc_step[WIDTH-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // The final multiplier bit is folded in on the same edge that writes the
  // result, so completion is detected while the counter still reads 1.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    w_mul_done  = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && !flush && w_mul_op) w_state_nxt = MUL_BUSY;
      end
      MUL_BUSY: begin
        if (flush) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = IDLE;
          w_mul_done  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_mop1   <= '0;
    end else if (r_state == IDLE) begin
      if (w_accept && w_mul_op) begin
        r_cnt    <= CNT_W'(WIDTH);
        r_mcand  <= {{WIDTH{1'b0}}, w_op1};
        r_mplier <= w_op2;
        r_acc    <= '0;
        r_mop1   <= w_op1;
      end
    end else if (flush) begin
      r_cnt <= '0;
    end else begin
      r_cnt    <= r_cnt - CNT_W'(1);
      r_acc    <= w_acc_step;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end
`else
  assign w_mul_op   = 1'b0;
  assign w_mul_done = 1'b0;
  assign w_mul_res  = '0;
  assign w_mul_op1  = '0;
  assign w_mul_st   = '0;
  assign in_ready   = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid         <= 1'b0;
      alu_result        <= '0;
      alu_first_operand <= '0;
      status            <= '0;
    end else begin
      out_valid <= w_sc_done | w_mul_done;
      if (w_sc_done) begin
        alu_result        <= w_res;
        alu_first_operand <= w_op1;
        status            <= w_st;
      end else if (w_mul_done) begin
        alu_result        <= w_mul_res;
        alu_first_operand <= w_mul_op1;
        status            <= w_mul_st;
      end
    end
  end

endmodule

// File: tb/tb_exec_unit_pipe.sv
// Scoreboard bench for exec_unit_pipe: the driver pushes expected results
// from a plain-arithmetic reference model; a negedge monitor pops and
// compares whenever out_valid is seen, and checks that outputs hold otherwise.
module tb_exec_unit_pipe;
  localparam int W = 16;
`ifdef EXEC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk = 1'b0, rst_n = 1'b1;
  logic         in_valid = 1'b0, in_ready, flush = 1'b0, imm_or_reg = 1'b0;
  logic [1:0]   sel_src = '0, sel_dst = '0;
  logic [3:0]   alu_ctrl = '0;
  logic [W-1:0] reg_src = '0, reg_dst = '0, immediate = '0;
  logic [W-1:0] src_from_ex = '0, dst_from_ex = '0, src_from_mem = '0, dst_from_mem = '0;
  logic         out_valid;
  logic [W-1:0] alu_result, alu_first_operand;
  logic [3:0]   status;

  exec_unit_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .imm_or_reg(imm_or_reg), .sel_src(sel_src), .sel_dst(sel_dst),
    .alu_ctrl(alu_ctrl), .reg_src(reg_src), .reg_dst(reg_dst), .immediate(immediate),
    .src_from_ex(src_from_ex), .dst_from_ex(dst_from_ex),
    .src_from_mem(src_from_mem), .dst_from_mem(dst_from_mem),
    .out_valid(out_valid), .alu_result(alu_result),
    .alu_first_operand(alu_first_operand), .status(status)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] op1;
    logic [3:0]   st;
    int           cyc;
  } exp_t;

  typedef struct {
    logic v, f, ior;
    logic [1:0] ss, sd;
    logic [3:0] op;
    logic [W-1:0] rs, rd, im, sx, dx, sm, dm;
  } stim_t;

  exp_t sb[$];
  int   checks = 0, errors = 0, cyc = 0;
  bit   mbusy = 1'b0;
  int   mrem = 0;
  exp_t mpend;
  logic [W-1:0] last_res = '0, last_op1 = '0;
  logic [3:0]   last_st = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: plain integer arithmetic on the opcode table
  function automatic void ref_alu(input logic [3:0] op, input logic [W-1:0] a, b,
                                  output logic [W-1:0] r, output logic c);
    longint unsigned A = a, B = b, M = 64'd1 << W, t;
    c = 1'b0;
    case (op)
      4'd1: begin t = (B + M - A) % M; c = (A > B); end
      4'd2: t = A & B;
      4'd3: t = A | B;
      4'd4: begin
        t = (B >= W) ? 0 : ((A << B) % M);
        c = (B >= 1 && B <= W) ? ((A >> (W - B)) & 1) != 0 : 1'b0;
      end
      4'd5: begin
        t = (B >= W) ? 0 : (A >> B);
        c = (B >= 1 && B <= W) ? ((A >> (B - 1)) & 1) != 0 : 1'b0;
      end
      4'd6: t = M - 1 - A;
      4'd7: t = B;
      4'd8: begin t = (A + 1) % M; c = (A + 1 >= M); end
      4'd9: begin t = (A + M - 1) % M; c = (A == 0); end
      4'd10: t = A;
      4'd11: begin
        if (MUL_EN) begin t = A * B; c = (t >= M); t = t % M; end
        else begin t = (A + B) % M; c = (A + B >= M); end
      end
      default: begin t = (A + B) % M; c = (A + B >= M); end
    endcase
    r = W'(t);
  endfunction

  function automatic stim_t nop();
    stim_t s;
    s.v = 0; s.f = 0; s.ior = 0; s.ss = 0; s.sd = 0; s.op = 0;
    s.rs = 0; s.rd = 0; s.im = 0; s.sx = 0; s.dx = 0; s.sm = 0; s.dm = 0;
    return s;
  endfunction

  // op1 from reg_src, op2 from immediate
  function automatic stim_t mk(input logic [3:0] op, input logic [W-1:0] a, b);
    stim_t s = nop();
    s.v = 1; s.op = op; s.rs = a; s.im = b;
    return s;
  endfunction

  function automatic logic [W-1:0] rv();
    case ($urandom_range(0, 3))
      0:       return W'($urandom_range(0, W + 2));
      1:       return {W{1'b1}};
      default: return W'($urandom);
    endcase
  endfunction

  // One cycle of stimulus; the model decides acceptance from its own state.
  task automatic step(input stim_t s);
    logic [W-1:0] a, b, r;
    logic c;
    exp_t e;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== !mbusy) begin
      errors++;
      $display("FAIL in_ready cyc %0d got %b exp %b", cyc, in_ready, !mbusy);
    end
    in_valid = s.v; flush = s.f; imm_or_reg = s.ior; sel_src = s.ss; sel_dst = s.sd;
    alu_ctrl = s.op; reg_src = s.rs; reg_dst = s.rd; immediate = s.im;
    src_from_ex = s.sx; dst_from_ex = s.dx; src_from_mem = s.sm; dst_from_mem = s.dm;
    a = (s.ss == 2'b01) ? s.sx : (s.ss == 2'b10) ? s.sm : s.rs;
    b = (s.sd == 2'b01) ? s.dx : (s.sd == 2'b10) ? s.dm : (s.ior ? s.rd : s.im);
    if (mbusy) begin
      if (s.f) mbusy = 1'b0;
      else begin
        mrem--;
        if (mrem == 0) begin
          mpend.cyc = cyc + 1;
          sb.push_back(mpend);
          mbusy = 1'b0;
        end
      end
    end else if (s.v && !s.f) begin
      ref_alu(s.op, a, b, r, c);
      e.res = r; e.op1 = a; e.st = {1'b1, c, r[W-1], (r == '0)}; e.cyc = cyc + 1;
      if (MUL_EN && s.op == 4'b1011) begin
        mbusy = 1'b1; mrem = W; mpend = e;
      end else sb.push_back(e);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      checks++;
      if (out_valid !== 1'b0 || alu_result !== '0 || alu_first_operand !== '0 || status !== 4'b0000) begin
        errors++;
        $display("FAIL reset_vals got v=%b r=%h o=%h s=%b exp 0/0000/0000/0000",
                 out_valid, alu_result, alu_first_operand, status);
      end
      last_res = '0; last_op1 = '0; last_st = '0;
    end else if (out_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL spurious_valid cyc %0d r=%h s=%b", cyc, alu_result, status);
      end else begin
        e = sb.pop_front();
        if (alu_result !== e.res || alu_first_operand !== e.op1 || status !== e.st || cyc != e.cyc) begin
          errors++;
          $display("FAIL result got r=%h o=%h s=%b cyc=%0d exp r=%h o=%h s=%b cyc=%0d",
                   alu_result, alu_first_operand, status, cyc, e.res, e.op1, e.st, e.cyc);
        end
      end
      last_res = alu_result; last_op1 = alu_first_operand; last_st = status;
    end else begin
      checks++;
      if (out_valid !== 1'b0 || alu_result !== last_res || alu_first_operand !== last_op1 || status !== last_st) begin
        errors++;
        $display("FAIL hold got v=%b r=%h o=%h s=%b exp v=0 r=%h o=%h s=%b",
                 out_valid, alu_result, alu_first_operand, status, last_res, last_op1, last_st);
      end
    end
  end

  initial begin
    stim_t s;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b0 || alu_result !== '0 || alu_first_operand !== '0 || status !== 4'b0000) begin
      errors++;
      $display("FAIL por_vals got v=%b r=%h o=%h s=%b exp 0/0000/0000/0000",
               out_valid, alu_result, alu_first_operand, status);
    end
    #14 rst_n = 1'b1;

    step(mk(4'd0, 16'hFFFF, 16'h0001));        // carry + zero
    step(mk(4'd5, 16'h0003, 16'd1));           // SHR, C=1
    step(mk(4'd5, 16'h0003, 16'd17));          // SHR beyond width
    step(mk(4'd4, 16'h8001, 16'd16));          // SHL by width
    step(mk(4'd9, 16'h0000, 16'h0000));        // DEC borrow
    s = mk(4'd1, 16'd0, 16'd0);                // forwarded SUB
    s.ss = 2'b01; s.sx = 16'd5; s.sd = 2'b10; s.dm = 16'd9; s.rs = 16'd77;
    step(s);
    s = mk(4'd0, 16'd3, 16'd4); s.f = 1'b1;    // flush in idle: no accept
    step(s);
    step(mk(4'd0, 16'h1234, 16'h1111));        // back-to-back ADD/AND/NOT
    step(mk(4'd2, 16'hF0F0, 16'h3C3C));
    step(mk(4'd6, 16'h00FF, 16'h0000));
    repeat (2) step(nop());

    step(mk(4'd11, 16'h0100, 16'h0100));       // MUL overflow
    repeat (W + 2) step(nop());
    step(mk(4'd11, 16'h0100, 16'h0100));       // MUL flushed at cycle 5
    repeat (4) step(nop());
    s = nop(); s.f = 1'b1; step(s);
    repeat (W + 2) step(nop());

    step(mk(4'd11, 16'h0123, 16'h0045));       // reset mid-operation
    @(posedge clk); #2;
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || alu_result !== '0 || status !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset got v=%b r=%h s=%b exp 0/0000/0000", out_valid, alu_result, status);
    end
    sb.delete(); mbusy = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      s.v = ($urandom_range(0, 9) < 8); s.f = ($urandom_range(0, 11) == 0);
      s.ior = 1'($urandom_range(0, 1)); s.ss = 2'($urandom_range(0, 3)); s.sd = 2'($urandom_range(0, 3));
      s.op = 4'($urandom_range(0, 15));
      s.rs = rv(); s.rd = rv(); s.im = rv(); s.sx = rv(); s.dx = rv(); s.sm = rv(); s.dm = rv();
      step(s);
    end
    repeat (W + 4) step(nop());
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/exec_unit_pipe.md
# exec_unit_pipe

Parametrised, registered successor to the single-cycle execute stage. Selects forwarded or register/immediate operands, performs the ALU operation and registers the result, first operand and 4-bit status into the EX/MEM boundary. Adds a valid/ready handshake, an iterative multi-cycle multiplier and a pipeline flush. Sits between the decode/register-read stage and the memory stage.

## Interface
- WIDTH, 16, datapath width in bits (≥4)
- CNT_W, $clog2(WIDTH)+1, multiply/shift counter width (derived, do not override)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation presented this cycle
- in_ready  out  1  unit can accept an operation
- flush  in  1  synchronous kill of in-flight work
- imm_or_reg  in  1  1: second operand from reg_dst; 0: from immediate
- sel_src, sel_dst  in  2 each  forwarding select: 00 register, 01 EX result, 10 MEM result, 11 register
- alu_ctrl  in  4  operation code
- reg_src, reg_dst, immediate  in  WIDTH each  operand sources
- src_from_ex, dst_from_ex, src_from_mem, dst_from_mem  in  WIDTH each  forwarded values
- out_valid  out  1  result registers hold a new result (one-cycle pulse)
- alu_result  out  WIDTH  registered result
- alu_first_operand  out  WIDTH  registered selected first operand (op1)
- status  out  4  {written, C, N, Z}; registered

## Operation
- op1 = forward-mux(sel_src); op2 = forward-mux(sel_dst) over (imm_or_reg ? reg_dst : immediate). Operands are captured on accept.
- Opcodes: 0000 ADD op1+op2; 0001 SUB op2−op1; 0010 AND; 0011 OR; 0100 SHL op1<<op2; 0101 SHR op1>>op2; 0110 NOT op1; 0111 PASS op2; 1000 INC op1+1; 1001 DEC op1−1; 1010 PASS op1; 1011 MUL; 11xx ADD.
- C: ADD/INC carry-out; SUB/DEC borrow (bit WIDTH of the WIDTH+1-bit difference); SHL/SHR last bit shifted out, 0 when op2==0 or op2>WIDTH; MUL 1 when any upper-half product bit is nonzero; logic/pass ops clear C.
- N = result[WIDTH−1]; Z = (result==0); written = 1 on every completed operation.
- FSM states IDLE, MUL_BUSY. IDLE: in_ready=1; accept on in_valid&in_ready; MUL goes to MUL_BUSY, all else completes at once. MUL_BUSY: in_ready=0; shift-add one multiplier bit per cycle, counter from WIDTH down; at count 0 write results and return to IDLE.
- flush: in IDLE suppresses any accept that cycle; in MUL_BUSY abandons the multiply, returns to IDLE, no out_valid. alu_result/status keep previous values.
- flush and completion in the same cycle: flush wins, no out_valid.

## Timing
- Reset (async, rst_n=0): state IDLE, in_ready=1 after release, out_valid=0, alu_result=0, alu_first_operand=0, status=4'b0000, counter=0.
- Single-cycle op accepted at edge N: outputs valid and out_valid=1 after edge N (one cycle), out_valid drops next cycle unless another op is accepted. Back-to-back throughput 1/cycle.
- MUL accepted at edge N: in_ready low for cycles N+1..N+WIDTH; results and out_valid after edge N+WIDTH; in_ready=1 again in that same cycle.
- Reset asserted mid-multiply: immediate return to reset values; partial product discarded.
- Outputs hold between out_valid pulses.

## Configuration
- EXEC_MUL_EN defined: MUL opcode 1011, MUL_BUSY state and multiplier datapath present.
- Undefined: no MUL_BUSY state; 1011 decodes as ADD; in_ready tied to 1 outside reset.

## Test plan
- Reset: rst_n=0 mid-operation -> out_valid=0, alu_result=0, status=0000 immediately.
- WIDTH=16, ADD 16'hFFFF+16'h0001 -> alu_result=0000, status=1101 (written, C, Z), out_valid one cycle later.
- SHR op1=16'h0003, op2=1 -> result 0001, C=1; op2=17 -> result 0000, C=0, Z=1.
- Forwarding: sel_src=01 src_from_ex=5, sel_dst=10 dst_from_mem=9, SUB -> result 4, alu_first_operand=5.
- EXEC_MUL_EN: MUL 16'h0100×16'h0100 -> in_ready low 16 cycles, result 0000, C=1, Z=1; repeat with flush at cycle 5 -> no out_valid, in_ready=1 next cycle.
- Back-to-back ADD, AND, NOT on consecutive cycles -> three consecutive out_valid pulses with correct results.
